// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryption path.
package aes_dec_pkg;

  localparam int unsigned NR      = 10;
  localparam logic [3:0]  RK_LAST = 4'd10;
  localparam int unsigned BLK_W   = 128;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine transform followed by the field inverse (x^254, with 0 -> 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] sq;
    logic [7:0] r;
    t  = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    r  = 8'h01;
    sq = t;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_dec_iter_ctrl_inv_round.sv
// One combinational inverse round; i_last drops InvMixColumns for the final round.
module inv_round
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_state,
  input  logic [BLK_W-1:0] i_rk,
  input  logic             i_last,
  output logic [BLK_W-1:0] o_state
);

  logic [BLK_W-1:0] w_sr;
  logic [BLK_W-1:0] w_sb;
  logic [BLK_W-1:0] w_ark;
  logic [BLK_W-1:0] w_mc;

  inv_shift_rows  u_isr (.i_data(i_state), .o_data(w_sr));
  inv_sub_bytes   u_isb (.i_data(w_sr),    .o_data(w_sb));

  assign w_ark = w_sb ^ i_rk;

  inv_mix_columns u_imc (.i_data(w_ark),   .o_data(w_mc));

  assign o_state = i_last ? w_ark : w_mc;

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns: each column multiplied by the {0e,0b,0d,09} circulant matrix.
module inv_mix_columns
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = i_data[127-32*c -: 8];
    assign w_a1 = i_data[119-32*c -: 8];
    assign w_a2 = i_data[111-32*c -: 8];
    assign w_a3 = i_data[103-32*c -: 8];
    assign o_data[127-32*c -: 8] = gmul(w_a0, 8'h0e) ^ gmul(w_a1, 8'h0b) ^ gmul(w_a2, 8'h0d) ^ gmul(w_a3, 8'h09);
    assign o_data[119-32*c -: 8] = gmul(w_a0, 8'h09) ^ gmul(w_a1, 8'h0e) ^ gmul(w_a2, 8'h0b) ^ gmul(w_a3, 8'h0d);
    assign o_data[111-32*c -: 8] = gmul(w_a0, 8'h0d) ^ gmul(w_a1, 8'h09) ^ gmul(w_a2, 8'h0e) ^ gmul(w_a3, 8'h0b);
    assign o_data[103-32*c -: 8] = gmul(w_a0, 8'h0b) ^ gmul(w_a1, 8'h0d) ^ gmul(w_a2, 8'h09) ^ gmul(w_a3, 8'h0e);
  end

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows: row r of the column-major state rotates right by r bytes.
module inv_shift_rows
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign o_data[127-8*(4*c+r) -: 8] = i_data[127-8*(4*((c+4-r)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes: inverse S-box applied to each of the 16 state bytes.
module inv_sub_bytes
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign o_data[127-8*i -: 8] = inv_sbox(i_data[127-8*i -: 8]);
  end

endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption controller: FSM, round counter and state register,
// fetching round keys 10..0 from a 1-cycle-latency key RAM.
module aes_dec_iter_ctrl
  import aes_dec_pkg::*;
#(
  parameter int unsigned NR   = aes_dec_pkg::NR,
  parameter int unsigned KA_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic [KA_W-1:0]  rk_addr,
  input  logic [BLK_W-1:0] rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
  output logic [3:0]       dbg_round
);

  state_t           r_fsm, w_fsm_nxt;
  logic [BLK_W-1:0] r_state, w_state_nxt;
  logic [BLK_W-1:0] w_round_out;
  logic [3:0]       r_rnd, w_rnd_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             w_last;

  assign w_last = (r_fsm == FINAL);

  inv_round u_inv_round (
    .i_state (r_state),
    .i_rk    (rk_data),
    .i_last  (w_last),
    .o_state (w_round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_rnd       <= w_rnd_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // rk_addr always leads the consuming state by one cycle to cover the RAM latency.
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_state_nxt     = r_state;
    w_rnd_nxt       = r_rnd;
    w_out_valid_nxt = r_out_valid;
    rk_addr         = KA_W'(RK_LAST);
    in_ready        = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = key_ready;
        if (in_valid && key_ready) begin
          w_state_nxt = in_data;
          w_rnd_nxt   = 4'(NR);
          w_fsm_nxt   = INIT;
        end
      end
      INIT: begin
        rk_addr     = KA_W'(r_rnd - 4'd1);
        w_state_nxt = r_state ^ rk_data;
        w_rnd_nxt   = r_rnd - 4'd1;
        w_fsm_nxt   = ROUND;
      end
      ROUND: begin
        rk_addr     = KA_W'(r_rnd - 4'd1);
        w_state_nxt = w_round_out;
        w_rnd_nxt   = r_rnd - 4'd1;
        if (r_rnd == 4'd1) w_fsm_nxt = FINAL;
      end
      FINAL: begin
        rk_addr         = '0;
        w_state_nxt     = w_round_out;
        w_out_valid_nxt = 1'b1;
        w_fsm_nxt       = DONE;
      end
      DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_fsm_nxt       = IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_fsm_nxt       = IDLE;
      end
    endcase
  end

  assign out_valid = r_out_valid;
  assign out_data  = (r_fsm == DONE) ? r_state : '0;
  assign busy      = (r_fsm != IDLE);
  assign dbg_round = r_rnd;

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Directed bench for aes_dec_iter_ctrl using the FIPS-197 C.1 vector and a modelled key RAM.
module tb_aes_dec_iter_ctrl;

  localparam logic [127:0] CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] INIT_ST = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_ready = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   dbg_round;

  logic [127:0] rk_mem [0:15];

  int checks = 0;
  int failures = 0;

  aes_dec_iter_ctrl #(.NR(10), .KA_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_addr   (rk_addr),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_round (dbg_round)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rk_data <= rk_mem[rk_addr];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc [2];
    int nacc;
    int nout;
    logic [127:0] outs [2];
    logic got;

    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    rk_mem[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk_mem[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk_mem[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk_mem[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk_mem[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk_mem[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk_mem[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk_mem[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk_mem[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk_mem[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk_mem[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    // Reset values
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk4("rst_dbg_round", dbg_round, 4'd0);
    chk128("rst_out_data", out_data, '0);
    chk1("rst_in_ready_nokey", in_ready, 1'b0);
    key_ready = 1'b1;
    #1;
    chk1("rst_in_ready_key", in_ready, 1'b1);
    key_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // key_ready low gates acceptance
    in_valid = 1'b1;
    in_data  = CT;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("nokey_in_ready", in_ready, 1'b0);
      chk1("nokey_busy", busy, 1'b0);
    end
    key_ready = 1'b1;
    #1;
    chk1("key_in_ready", in_ready, 1'b1);
    chk4("idle_rk_addr", rk_addr, 4'd10);

    // FIPS-197 block: latency and key fetch order
    step();
    chk4("init_dbg_round", dbg_round, 4'd10);
    chk4("init_rk_addr", rk_addr, 4'd9);
    chk1("init_busy", busy, 1'b1);
    in_valid  = 1'b0;
    in_data   = '1;
    key_ready = 1'b0;
    step();
    chk128("after_init_state", dut.r_state, INIT_ST);
    chk4("round9_rk_addr", rk_addr, 4'd8);
    for (int n = 3; n <= 11; n++) begin
      step();
      chk4("walk_rk_addr", rk_addr, (n <= 10) ? 4'(10 - n) : 4'd0);
      chk1("walk_out_valid", out_valid, 1'b0);
    end
    step();
    chk1("lat12_out_valid", out_valid, 1'b1);
    chk128("c1_plaintext", out_data, PT);
    chk4("done_rk_addr", rk_addr, 4'd10);

    // Backpressure
    key_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk128("bp_out_data", out_data, PT);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk1("hs_out_valid", out_valid, 1'b0);
    chk1("hs_in_ready", in_ready, 1'b1);
    chk1("hs_busy", busy, 1'b0);
    chk128("hs_out_data", out_data, '0);

    // Back-to-back blocks
    in_valid  = 1'b1;
    in_data   = CT;
    out_ready = 1'b1;
    nacc = 0;
    nout = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_valid && in_ready && nacc < 2) begin
        acc[nacc] = i;
        nacc++;
      end
      step();
      if (nacc == 2) in_valid = 1'b0;
      if (out_valid && nout < 2) begin
        outs[nout] = out_data;
        nout++;
      end
      if (nout == 2) break;
    end
    chki("b2b_accepts", nacc, 2);
    chki("b2b_outputs", nout, 2);
    if (nacc == 2) chki("b2b_accept_gap", acc[1] - acc[0], 13);
    if (nout == 2) begin
      chk128("b2b_pt0", outs[0], PT);
      chk128("b2b_pt1", outs[1], PT);
    end
    step();
    out_ready = 1'b0;

    // Reset in the middle of ROUND
    in_valid = 1'b1;
    in_data  = CT;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (dbg_round == 4'd5) break;
      step();
    end
    chk4("pre_rst_round", dbg_round, 4'd5);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk4("mid_rst_dbg_round", dbg_round, 4'd0);
    chk128("mid_rst_out_data", out_data, '0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk4("mid_rst_rk_addr", rk_addr, 4'd10);
    @(negedge clk) rst_n = 1'b1;
    step();
    in_valid  = 1'b1;
    in_data   = CT;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid) begin
        got = 1'b1;
        chk128("post_rst_plaintext", out_data, PT);
        break;
      end
    end
    chk1("post_rst_done", got, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_dec_iter_ctrl.md
Name: aes_dec_iter_ctrl

Overview:
Iterative AES-128 decryption engine controller. It accepts one 128-bit ciphertext block per valid/ready handshake and fetches round keys from an external synchronous key RAM in order 10..0. One inverse round runs per clock through a shared combinational round datapath, and the plaintext is presented on a valid/ready output. It sits between the host block interface and the key-schedule RAM in the decryption path.

Parameters:
NR, 10, number of rounds (fixed for AES-128; other values unsupported)
KA_W, 4, round-key RAM address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
key_ready  in  1  key-schedule RAM fully loaded; gates acceptance only
in_valid  in  1  ciphertext valid
in_ready  out  1  block can be accepted
in_data  in  128  ciphertext; [127:120] = byte 0, column-major
rk_addr  out  KA_W  round-key index; combinational from FSM
rk_data  in  128  round key for the rk_addr presented in the previous cycle (1-cycle RAM latency)
out_valid  out  1  plaintext valid
out_ready  in  1  consumer accepts plaintext
out_data  out  128  plaintext, same byte order as in_data
busy  out  1  high in every state except IDLE
dbg_round  out  4  current round counter

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, state_reg=0, rnd=0, out_valid=0, busy=0, dbg_round=0. out_data=0. in_ready follows IDLE & key_ready.
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE: in_ready = key_ready. rk_addr = 10, so rk10 is on rk_data in the following cycle. On in_valid & in_ready: state_reg <= in_data, rnd <= 10, go to INIT. If key_ready=0, in_valid is ignored and nothing is latched.
- INIT (1 cycle): state_reg <= state_reg ^ rk_data. rk_addr = 9. rnd <= 9. Go to ROUND.
- ROUND (rnd 9..1, 9 cycles): state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(state_reg)) ^ rk_data). rk_addr = rnd-1. rnd <= rnd-1. When rnd==1, go to FINAL.
- FINAL (rnd 0): state_reg <= InvSubBytes(InvShiftRows(state_reg)) ^ rk_data. Set out_valid <= 1 and go to DONE.
- DONE: out_valid=1 and out_data=state_reg, held stable until out_ready. On out_ready: out_valid <= 0, go to IDLE. in_ready stays 0 in DONE, so a new block is accepted no earlier than the cycle after the output handshake.
- Latency: accept in cycle 0 gives out_valid high from cycle 12. Throughput is one block per 13 cycles minimum with out_ready tied high.
- out_data is 0 outside DONE. busy = (state != IDLE). dbg_round = rnd.
- rk_addr in DONE = 10, identical to IDLE, so the RAM pre-fetches rk10.
- key_ready falling mid-block is ignored; the block completes.
- Reset asserted mid-operation aborts immediately. No output is produced and the next block after reset is processed normally.
- in_valid/in_data changing while busy have no effect.
- Illegal FSM encodings recover to IDLE.

Decomposition:
- Shared package aes_dec_pkg: state enum (IDLE, INIT, ROUND, FINAL, DONE), NR=10, RK_LAST=4'd10, block width 128.
- One combinational sub-module, inv_round: inputs state, rk, last. It instantiates the team's existing inv_shift_rows, inv_sub_bytes and inv_mix_columns, and bypasses InvMixColumns when last=1.
- The controller holds the FSM, round counter and state register only.

Test Plan:
- FIPS-197 C.1: RAM loaded from key 000102030405060708090a0b0c0d0e0f; in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid rises exactly 12 cycles after accept.
- Key fetch order: same block -> rk_addr sequence 10 (accept cycle), 9, 8, ..., 1, 0 (FINAL), then 10. dbg_round in INIT = 10. After INIT, state_reg = 7ad5fda789ef4e272bca100b3d9ff59f.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_data held constant and in_ready=0. out_ready pulse -> IDLE next cycle and in_ready=1.
- key_ready=0 with in_valid=1 for 5 cycles -> in_ready=0, busy=0, no acceptance. Raising key_ready -> accept on that cycle.
- Back-to-back: two FIPS-197 blocks with out_ready=1 -> both plaintexts correct, second accept 13 cycles after the first.
- rst_n asserted in ROUND at rnd=5 -> all outputs at reset values asynchronously. A subsequent block decrypts correctly.
